// File: rtl/numled_scan_ctrl.sv
// Seven-segment scan controller: arbitrated CPU/debug writes to a double-buffered display value, scan/blink sequencing.
// Grants are combinational (same-cycle); a losing requester sees ready/ack low and holds; disp_data updates at frame_end.
module numled_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wr_en,
    input  logic        bus_rd_en,
    input  logic [1:0]  bus_addr,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_data,
    output logic        dbg_ack,
    output logic [31:0] disp_data,
    output logic        disp_light,
    output logic        scan_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    typedef struct packed {
        logic freeze;
        logic dbg_en;
        logic blink;
        logic enable;
    } ctrl_t;

    state_t        state;
    ctrl_t         ctrl;
    logic [31:0]   shadow;
    logic          prio_dbg;
    logic [PW-1:0] presc;
    logic [2:0]    digit;
    logic [BW-1:0] blink_cnt;

    logic cpu_sh_req, dbg_elig, cpu_win, dbg_win;
    logic run, tick_nxt, frame_end, blink_exp;

    always_comb begin
        cpu_sh_req = bus_wr_en && (bus_addr == 2'd0);
        dbg_elig   = dbg_valid && ctrl.dbg_en && !ctrl.freeze;
        cpu_win    = cpu_sh_req && (!dbg_elig || !prio_dbg);
        dbg_win    = dbg_elig && (!cpu_sh_req || prio_dbg);
        // Grants are forced low while reset is asserted so an in-flight request is aborted.
        bus_ready  = !rst && (bus_wr_en ? ((bus_addr != 2'd0) || cpu_win) : bus_rd_en);
        dbg_ack    = !rst && dbg_win;

        run       = (state != OFF) && ctrl.enable;
        tick_nxt  = run && (presc == PRESC_MAX);
        frame_end = scan_tick && (digit == 3'd7);
        blink_exp = frame_end && (blink_cnt == BLINK_MAX);
    end

    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr)
            2'd0: bus_rdata = shadow;
            2'd1: bus_rdata = {28'd0, ctrl};
            2'd2: bus_rdata = disp_data;
            2'd3: bus_rdata = {27'd0, state, digit};
            default: bus_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl      <= '0;
            shadow    <= 32'd0;
            prio_dbg  <= 1'b0;
            disp_data <= 32'd0;
            presc     <= '0;
            digit     <= 3'd0;
            scan_tick <= 1'b0;
            blink_cnt <= '0;
        end else begin
            if (bus_wr_en && (bus_addr == 2'd1) && bus_be[0])
                ctrl <= ctrl_t'(bus_wdata[3:0]);

            if (cpu_win) begin
                for (int i = 0; i < 4; i++)
                    if (bus_be[i])
                        shadow[8*i +: 8] <= bus_wdata[8*i +: 8];
            end else if (dbg_win) begin
                shadow <= dbg_data;
            end

            // Priority passes to the loser of a conflict so neither side can starve.
            if (cpu_sh_req && dbg_elig)
                prio_dbg <= !prio_dbg;

            scan_tick <= tick_nxt;
            if (!run) begin
                presc <= '0;
                digit <= 3'd0;
            end else begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
                if (scan_tick)
                    digit <= digit + 3'd1;
            end

            if (!run || !ctrl.blink)
                blink_cnt <= '0;
            else if (frame_end)
                blink_cnt <= blink_exp ? '0 : blink_cnt + BW'(1);

            // Old shadow is sampled here, so a write in the frame_end cycle waits a frame.
            if ((state == OFF) || frame_end)
                disp_data <= shadow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            disp_light <= 1'b0;
        end else if (!ctrl.enable) begin
            state      <= OFF;
            disp_light <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state      <= SCAN;
                    disp_light <= 1'b1;
                end
                SCAN: begin
                    if (ctrl.blink && blink_exp) begin
                        state      <= BLANK;
                        disp_light <= 1'b0;
                    end else begin
                        disp_light <= 1'b1;
                    end
                end
                BLANK: begin
                    if (!ctrl.blink || blink_exp) begin
                        state      <= SCAN;
                        disp_light <= 1'b1;
                    end else begin
                        disp_light <= 1'b0;
                    end
                end
                default: begin
                    state      <= OFF;
                    disp_light <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_numled_scan_ctrl.sv
// Directed bench for numled_scan_ctrl with CLK_DIV=4, BLINK_FRAMES=2 (frame = 32 cycles, blink half = 64 cycles).
module tb_numled_scan_ctrl;

    localparam int CLK_DIV      = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wr_en, bus_rd_en;
    logic [1:0]  bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic [31:0] disp_data;
    logic        disp_light, scan_tick;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    numled_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk(clk), .rst(rst),
        .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .disp_data(disp_data), .disp_light(disp_light), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_wr_en = 1'b1; bus_addr = a; bus_be = be; bus_wdata = d;
        #1;
        chk("wr_ready", {31'd0, bus_ready}, 32'd1);
        step();
        bus_wr_en = 1'b0; bus_be = 4'd0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus_rd_en = 1'b1; bus_addr = a;
        #1;
        chk({tag, "_rdy"}, {31'd0, bus_ready}, 32'd1);
        chk(tag, bus_rdata, exp_q.pop_front());
        step();
        bus_rd_en = 1'b0;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!scan_tick && cycles < 64);
        chk("tick_seen", {31'd0, scan_tick}, 32'd1);
    endtask

    // Returns mid-cycle in a frame_end cycle (tick on digit 7), checking the current cycle first.
    task automatic wait_frame_end();
        int n;
        n = 0;
        bus_rd_en = 1'b1; bus_addr = 2'd3;
        #1;
        while (!(scan_tick && bus_rdata[2:0] == 3'd7) && n < 200) begin
            step();
            #1;
            n++;
        end
        chk("frame_end_seen", {31'd0, (scan_tick && bus_rdata[2:0] == 3'd7)}, 32'd1);
        bus_rd_en = 1'b0;
    endtask

    task automatic measure_run(input logic value, output int n);
        n = 0;
        while (disp_light == value && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        int cyc, nt;
        rst = 1'b1;
        bus_wr_en = 1'b0; bus_rd_en = 1'b0; bus_addr = 2'd0; bus_be = 4'd0; bus_wdata = 32'd0;
        dbg_valid = 1'b0; dbg_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp_data", disp_data, 32'd0);
        chk("rst_light", {31'd0, disp_light}, 32'd0);
        chk("rst_tick", {31'd0, scan_tick}, 32'd0);
        chk("rst_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        rst = 1'b0;
        step();
        bus_read("rst_shadow", 2'd0, 32'd0);
        bus_read("rst_ctrl", 2'd1, 32'd0);
        bus_read("rst_status", 2'd3, 32'd0);

        // Debug is ineligible while dbg_en is clear.
        dbg_valid = 1'b1; dbg_data = 32'hFFFF_FFFF;
        #1;
        chk("dbg_no_en_ack", {31'd0, dbg_ack}, 32'd0);
        step();
        dbg_valid = 1'b0;

        // 1: enable, load value, tick period and first frame update.
        bus_write(2'd1, 4'hF, 32'h1);
        bus_write(2'd0, 4'hF, 32'h1234_5678);
        for (int t = 1; t <= 8; t++) begin
            wait_tick(cyc);
            if (t > 1) chk("tick_period", cyc, 32'd4);
        end
        chk("light_scan", {31'd0, disp_light}, 32'd1);
        chk("disp_before_fe", disp_data, 32'd0);
        step();
        chk("disp_after_fe", disp_data, 32'h1234_5678);

        // 2: partial write lands in shadow now, in disp_data at the next frame_end.
        bus_write(2'd0, 4'b0011, 32'hAABB_CCDD);
        bus_read("shadow_merge", 2'd0, 32'h1234_CCDD);
        bus_write(2'd2, 4'hF, 32'hDEAD_BEEF);
        bus_read("vis_mid_frame", 2'd2, 32'h1234_5678);
        bus_read("shadow_after_ro", 2'd0, 32'h1234_CCDD);
        wait_frame_end();
        chk("disp_at_fe", disp_data, 32'h1234_5678);
        step();
        chk("disp_next_frame", disp_data, 32'h1234_CCDD);

        // 3: conflicting CPU/debug writes alternate starting with CPU.
        bus_write(2'd1, 4'hF, 32'h5);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        for (int i = 0; i < 4; i++) begin
            bus_wr_en = 1'b1; bus_addr = 2'd0; bus_be = 4'hF; bus_wdata = 32'h1111_0000 + 32'(i);
            dbg_valid = 1'b1; dbg_data = 32'hDB00_0000 + 32'(i);
            #1;
            chk("arb_grant", {30'd0, bus_ready, dbg_ack}, exp_q.pop_front());
            step();
        end
        bus_wr_en = 1'b0; dbg_valid = 1'b0;
        bus_read("arb_shadow", 2'd0, 32'hDB00_0003);

        // Ctrl only takes byte 0 and keeps bits 3:0.
        bus_write(2'd1, 4'b1110, 32'h0);
        bus_read("ctrl_be", 2'd1, 32'h5);
        bus_write(2'd1, 4'b0001, 32'hFFFF_FFF5);
        bus_read("ctrl_mask", 2'd1, 32'h5);

        // 4: freeze blocks debug; clearing it grants the cycle after.
        bus_write(2'd1, 4'hF, 32'hD);
        dbg_valid = 1'b1; dbg_data = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_ack", {31'd0, dbg_ack}, 32'd0);
            step();
        end
        #1;
        chk("freeze_ack_clr_cycle", {31'd0, dbg_ack}, 32'd0);
        bus_write(2'd1, 4'h1, 32'h5);
        #1;
        chk("unfreeze_ack", {31'd0, dbg_ack}, 32'd1);
        step();
        dbg_valid = 1'b0;
        bus_read("dbg_shadow", 2'd0, 32'hCAFE_F00D);

        // 5: blink period 64/64, then clearing blink in BLANK resumes SCAN.
        bus_write(2'd1, 4'hF, 32'h3);
        wait_frame_end();
        step();
        wait_frame_end();
        chk("blink_pre", {31'd0, disp_light}, 32'd1);
        step();
        chk("blink_off", {31'd0, disp_light}, 32'd0);
        measure_run(1'b0, nt);
        chk("blink_off_len", nt, 32'd64);
        measure_run(1'b1, nt);
        chk("blink_on_len", nt, 32'd64);
        bus_rd_en = 1'b1; bus_addr = 2'd3;
        #1;
        chk("blank_state", {30'd0, bus_rdata[4:3]}, 32'd2);
        bus_rd_en = 1'b0;
        bus_write(2'd1, 4'hF, 32'h1);
        chk("blink_clr_still_blank", {31'd0, disp_light}, 32'd0);
        step();
        chk("blink_clr_scan", {31'd0, disp_light}, 32'd1);

        // 6: disable mid-frame, then async reset mid-write.
        repeat (3) wait_tick(cyc);
        bus_write(2'd1, 4'hF, 32'h0);
        step();
        chk("off_light", {31'd0, disp_light}, 32'd0);
        bus_read("off_status", 2'd3, 32'd0);
        bus_write(2'd0, 4'hF, 32'h55AA_55AA);
        step();
        chk("off_tracks_shadow", disp_data, 32'h55AA_55AA);
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            if (scan_tick) nt++;
            step();
        end
        chk("off_no_ticks", nt, 32'd0);
        bus_write(2'd1, 4'hF, 32'h1);
        step();
        step();
        chk("reen_light", {31'd0, disp_light}, 32'd1);
        bus_wr_en = 1'b1; bus_addr = 2'd0; bus_be = 4'hF; bus_wdata = 32'h0000_0099;
        #1;
        chk("pre_rst_ready", {31'd0, bus_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_disp", disp_data, 32'd0);
        chk("arst_light", {31'd0, disp_light}, 32'd0);
        chk("arst_ready", {31'd0, bus_ready}, 32'd0);
        chk("arst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("arst_tick", {31'd0, scan_tick}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, bus_ready}, 32'd1);
        step();
        bus_wr_en = 1'b0;
        bus_read("post_rst_shadow", 2'd0, 32'h0000_0099);
        bus_read("post_rst_ctrl", 2'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
